ghash_sequencer_fsm: RTL

Control FSM for the GHASH datapath. It accepts a job descriptor with AAD and text block counts, then walks the input blocks through the shared GF(2^128) multiplier one block at a time. It ends each job with the length block and flags the final tag. The block is control only: it drives the GHASH input mux, the multiplier load strobe, the accumulator enable/clear, and the upstream block handshake.

---
 rtl/ghash_ctrl_pkg.sv | 26 ++
 rtl/ghash_latency_timer.sv | 33 +++
 rtl/ghash_sequencer_fsm.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ghash_ctrl_pkg.sv
// Shared encodings for the GHASH control path: FSM state codes and
// GHASH input-mux select codes.
package ghash_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_BLK = 3'd1,
      ST_MULT     = 3'd2,
      ST_LEN      = 3'd3,
      ST_FINISH   = 3'd4
   } state_t;

   localparam logic [1:0] SEL_AAD  = 2'd0;
   localparam logic [1:0] SEL_TXT  = 2'd1;
   localparam logic [1:0] SEL_LEN  = 2'd2;
   localparam logic [1:0] SEL_ZERO = 2'd3;

   // Unused codes 5-7 count as idle, so they never report busy.
   function automatic logic is_busy_state(input state_t s);
      case (s)
         ST_WAIT_BLK, ST_MULT, ST_LEN, ST_FINISH: return 1'b1;
         default:                                return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ghash_latency_timer.sv
// Multiplier latency timer: counts 0..limit while enabled, wraps to 0 on the
// cycle it reports done.
module ghash_latency_timer #(
   parameter int NB_TIMER = 3
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_enable,
   input  logic                i_clear,
   input  logic [NB_TIMER-1:0] i_limit,
   output logic                o_done
);

   logic [NB_TIMER-1:0] r_count;

   assign o_done = (r_count == i_limit);

   // Latency counter, frozen when neither clear nor enable is asserted.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_count <= {NB_TIMER{1'b0}};
      end else if (i_clear) begin
         r_count <= {NB_TIMER{1'b0}};
      end else if (i_enable) begin
         if (o_done) begin
            r_count <= {NB_TIMER{1'b0}};
         end else begin
            r_count <= r_count + NB_TIMER'(1);
         end
      end
   end

endmodule

// File: rtl/ghash_sequencer_fsm.sv
// GHASH control FSM: walks AAD then text blocks through the shared
// multiplier, finishes with the length block and flags the final tag.
module ghash_sequencer_fsm
   import ghash_ctrl_pkg::*;
#(
   parameter int NB_STATE     = 3,
   parameter int NB_AAD_CNT   = 8,
   parameter int NB_TXT_CNT   = 8,
   parameter int MULT_LATENCY = 4,
   parameter int NB_TIMER     = 3
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_valid,
   input  logic                  i_start,
   input  logic [NB_AAD_CNT-1:0] i_n_aad_blocks,
   input  logic [NB_TXT_CNT-1:0] i_n_txt_blocks,
   input  logic                  i_block_valid,
   output logic                  o_block_ready,
   output logic [1:0]            o_sel,
   output logic                  o_mult_load,
   output logic                  o_acc_clear,
   output logic                  o_acc_enable,
   output logic                  o_tag_valid,
   output logic                  o_busy,
   output logic [NB_STATE-1:0]   o_state
);

   localparam logic [NB_TIMER-1:0] TIMER_LIMIT = NB_TIMER'(MULT_LATENCY - 1);

   state_t                r_state;
   state_t                w_next_state;
   logic [NB_AAD_CNT-1:0] r_n_aad;
   logic [NB_TXT_CNT-1:0] r_n_txt;
   logic [NB_AAD_CNT-1:0] r_aad_cnt;
   logic [NB_TXT_CNT-1:0] r_txt_cnt;
   logic                  r_len_done;
   logic [1:0]            r_sel;

   logic       w_is_aad;
   logic       w_more;
   logic       w_accept;
   logic       w_blk_load;
   logic       w_len_load;
   logic       w_ready;
   logic       w_acc_enable;
   logic       w_tag;
   logic [1:0] w_sel;
   logic       w_timer_done;
   logic       w_timer_enable;
   logic       w_timer_clear;

   assign w_is_aad = (r_aad_cnt != r_n_aad);
   assign w_more   = w_is_aad || (r_txt_cnt != r_n_txt);

   assign w_timer_enable = i_valid && (r_state == ST_MULT);
   assign w_timer_clear  = i_valid && (r_state != ST_MULT);

   ghash_latency_timer #(
      .NB_TIMER (NB_TIMER)
   ) u_timer (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_enable (w_timer_enable),
      .i_clear  (w_timer_clear),
      .i_limit  (TIMER_LIMIT),
      .o_done   (w_timer_done)
   );

   // State register; i_valid low freezes the FSM.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else if (i_valid) begin
         r_state <= w_next_state;
      end
   end

   // Next-state and pulse decode; every pulse is gated by i_valid.
   always_comb begin
      w_next_state = r_state;
      w_sel        = SEL_ZERO;
      w_ready      = 1'b0;
      w_accept     = 1'b0;
      w_blk_load   = 1'b0;
      w_len_load   = 1'b0;
      w_acc_enable = 1'b0;
      w_tag        = 1'b0;
      case (r_state)
         ST_WAIT_BLK: begin
            w_ready = i_valid;
            w_sel   = w_is_aad ? SEL_AAD : SEL_TXT;
            if (i_valid && i_block_valid) begin
               w_blk_load   = 1'b1;
               w_next_state = ST_MULT;
            end else begin
               w_next_state = ST_WAIT_BLK;
            end
         end
         ST_MULT: begin
            w_sel = r_sel;
            if (i_valid && w_timer_done) begin
               w_acc_enable = 1'b1;
               if (w_more) begin
                  w_next_state = ST_WAIT_BLK;
               end else if (!r_len_done) begin
                  w_next_state = ST_LEN;
               end else begin
                  w_next_state = ST_FINISH;
               end
            end else begin
               w_next_state = ST_MULT;
            end
         end
         ST_LEN: begin
            w_sel = SEL_LEN;
            if (i_valid) begin
               w_len_load   = 1'b1;
               w_next_state = ST_MULT;
            end else begin
               w_next_state = ST_LEN;
            end
         end
         ST_FINISH: begin
            if (i_valid) begin
               w_tag        = 1'b1;
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_FINISH;
            end
         end
         default: begin
            // ST_IDLE and the unused codes share idle behaviour.
            if (i_valid && i_start) begin
               w_accept = 1'b1;
               if ((i_n_aad_blocks != {NB_AAD_CNT{1'b0}}) ||
                   (i_n_txt_blocks != {NB_TXT_CNT{1'b0}})) begin
                  w_next_state = ST_WAIT_BLK;
               end else begin
                  w_next_state = ST_LEN;
               end
            end else begin
               w_next_state = ST_IDLE;
            end
         end
      endcase
   end

   // Job bookkeeping: latched counts, block counters, length flag, mux hold.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_n_aad    <= {NB_AAD_CNT{1'b0}};
         r_n_txt    <= {NB_TXT_CNT{1'b0}};
         r_aad_cnt  <= {NB_AAD_CNT{1'b0}};
         r_txt_cnt  <= {NB_TXT_CNT{1'b0}};
         r_len_done <= 1'b0;
         r_sel      <= SEL_ZERO;
      end else if (w_accept) begin
         r_n_aad    <= i_n_aad_blocks;
         r_n_txt    <= i_n_txt_blocks;
         r_aad_cnt  <= {NB_AAD_CNT{1'b0}};
         r_txt_cnt  <= {NB_TXT_CNT{1'b0}};
         r_len_done <= 1'b0;
      end else if (w_blk_load) begin
         // Hold the select of the block in flight for the whole multiply.
         r_sel <= w_sel;
         if (w_is_aad) begin
            r_aad_cnt <= r_aad_cnt + NB_AAD_CNT'(1);
         end else begin
            r_txt_cnt <= r_txt_cnt + NB_TXT_CNT'(1);
         end
      end else if (w_len_load) begin
         r_sel      <= SEL_LEN;
         r_len_done <= 1'b1;
      end
   end

   assign o_block_ready = w_ready;
   assign o_sel         = w_sel;
   assign o_mult_load   = w_blk_load || w_len_load;
   assign o_acc_clear   = w_accept;
   assign o_acc_enable  = w_acc_enable;
   assign o_tag_valid   = w_tag;
   assign o_busy        = is_busy_state(r_state);
   assign o_state       = NB_STATE'(r_state);

endmodule
